led_stretcher: RTL

- Output-side counterpart of the debouncer path: consumes clean one-cycle edge pulses (sig_pedge / sig_nedge style) and drives a human-visible indicator level.
- Guarantees minimum on-time and minimum off-time so that short or rapid events stay visible on front-panel LEDs.
- Sits between debouncer_pulse (or any event source such as note-on/note-off strobes) and the board LED pins.

---
 rtl/led_stretcher_pkg.sv | 22 ++
 rtl/led_stretcher_if.sv | 41 ++++
 rtl/led_stretcher_hold_timer.sv | 44 ++++
 rtl/led_stretcher.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/led_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED stretcher slice.
//   led_state_t : four-state indicator FSM encoding (2 bits)
//   max_u       : unsigned max, used to size the hold counter
// Optional feature macro used elsewhere in this slice: LED_PWM_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package led_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        ON_HOLD  = 2'd1,
        ON       = 2'd2,
        OFF_HOLD = 2'd3
    } led_state_t;

    function automatic int max_u(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_stretcher_if.sv
// -----------------------------------------------------------------------------
// led_stretcher_if
// Groups the event inputs and indicator outputs of led_stretcher.
//   set_pulse, clr_pulse : one-cycle on/off requests (event source -> stretcher)
//   led_level            : registered indicator level
//   led                  : pin drive (PWM-gated when LED_PWM_EN is defined)
//   busy                 : minimum-time hold in progress
//   duty                 : PWM duty, only present when LED_PWM_EN is defined
// Modports: master = event source / board side, slave = led_stretcher.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface led_stretcher_if #(
    parameter int PWM_BITS = 4
);
    logic set_pulse;
    logic clr_pulse;
    logic led_level;
    logic led;
    logic busy;
`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] duty;

    modport master (
        output set_pulse, clr_pulse, duty,
        input  led_level, led, busy
    );
    modport slave (
        input  set_pulse, clr_pulse, duty,
        output led_level, led, busy
    );
`else
    modport master (
        output set_pulse, clr_pulse,
        input  led_level, led, busy
    );
    modport slave (
        input  set_pulse, clr_pulse,
        output led_level, led, busy
    );
`endif
endinterface

// File: rtl/led_stretcher_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Loadable down-counter for the minimum on/off hold.
//   clk      : system clock
//   rst      : asynchronous active-low reset (count -> 0)
//   load     : load load_val this cycle (takes priority over decrement)
//   load_val : value to load
//   done     : count is zero
// The count only decrements while nonzero, so it never wraps.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module hold_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = load_val;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/led_stretcher.sv
// -----------------------------------------------------------------------------
// led_stretcher
// Turns one-cycle set/clear event pulses into a human-visible indicator level
// with guaranteed minimum on-time (MIN_ON) and off-time (MIN_OFF).
//   clk : system clock, posedge
//   rst : asynchronous active-low reset
//   bus : led_stretcher_if.slave (set_pulse, clr_pulse in; led_level, led,
//         busy out; duty in when LED_PWM_EN is defined)
// Optional macro LED_PWM_EN: adds PWM_BITS parameter, a free-running PWM
// counter and a registered PWM-gated led output. Without it led = led_level.
// A same-cycle set and clear is treated as a set.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module led_stretcher
    import led_pkg::*;
#(
    parameter int MIN_ON   = 4,
    parameter int MIN_OFF  = 3
`ifdef LED_PWM_EN
    ,
    parameter int PWM_BITS = 4
`endif
) (
    input  logic            clk,
    input  logic            rst,
    led_stretcher_if.slave  bus
);

    localparam int CNT_W = $clog2(max_u(MIN_ON, MIN_OFF) + 1);
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF - 1);

    led_state_t       state_reg, state_next;
    logic             led_level_reg, led_level_next;
    logic             pend_set_reg, pend_set_next;
    logic             pend_clr_reg, pend_clr_next;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             timer_done;

    logic set_in;
    logic clr_in;

    assign set_in = bus.set_pulse;
    assign clr_in = bus.clr_pulse;

    hold_timer #(
        .W (CNT_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .done     (timer_done)
    );

    always_comb begin
        state_next     = state_reg;
        led_level_next = led_level_reg;
        pend_set_next  = pend_set_reg;
        pend_clr_next  = pend_clr_reg;
        timer_load     = 1'b0;
        timer_load_val = '0;

        case (state_reg)
            OFF: begin
                if (set_in) begin
                    state_next     = ON_HOLD;
                    led_level_next = 1'b1;
                    timer_load     = 1'b1;
                    timer_load_val = ON_LOAD;
                end
            end

            ON_HOLD: begin
                // Last event wins; a simultaneous set overrides the clear.
                if (set_in) begin
                    pend_clr_next = 1'b0;
                end else if (clr_in) begin
                    pend_clr_next = 1'b1;
                end
                if (timer_done) begin
                    pend_clr_next = 1'b0;
                    if (!set_in && (pend_clr_reg || clr_in)) begin
                        state_next     = OFF_HOLD;
                        led_level_next = 1'b0;
                        timer_load     = 1'b1;
                        timer_load_val = OFF_LOAD;
                    end else begin
                        state_next = ON;
                    end
                end
            end

            ON: begin
                // No retrigger: set is ignored while steadily on.
                if (clr_in && !set_in) begin
                    state_next     = OFF_HOLD;
                    led_level_next = 1'b0;
                    timer_load     = 1'b1;
                    timer_load_val = OFF_LOAD;
                end
            end

            OFF_HOLD: begin
                if (set_in) begin
                    pend_set_next = 1'b1;
                end else if (clr_in) begin
                    pend_set_next = 1'b0;
                end
                if (timer_done) begin
                    pend_set_next = 1'b0;
                    if (set_in || (pend_set_reg && !clr_in)) begin
                        state_next     = ON_HOLD;
                        led_level_next = 1'b1;
                        timer_load     = 1'b1;
                        timer_load_val = ON_LOAD;
                    end else begin
                        state_next = OFF;
                    end
                end
            end

            default: begin
                state_next     = OFF;
                led_level_next = 1'b0;
                pend_set_next  = 1'b0;
                pend_clr_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= OFF;
            led_level_reg <= 1'b0;
            pend_set_reg  <= 1'b0;
            pend_clr_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            led_level_reg <= led_level_next;
            pend_set_reg  <= pend_set_next;
            pend_clr_reg  <= pend_clr_next;
        end
    end

    assign bus.led_level = led_level_reg;
    assign bus.busy      = (state_reg == ON_HOLD) || (state_reg == OFF_HOLD);

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic                led_pwm_reg;

    // Gate is registered, so led lags the compare by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_reg <= '0;
            led_pwm_reg <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
            led_pwm_reg <= led_level_reg & (pwm_cnt_reg < bus.duty);
        end
    end

    assign bus.led = led_pwm_reg;
`else
    assign bus.led = led_level_reg;
`endif

endmodule
